fifo_wr_arbiter: RTL and testbench

Write-port arbiter and sequencer for the TX FIFO write side. It shares the single W-bit FIFO write port between two requesters:
- a 2W-bit ALU result, written as two bytes, LSB first;
- a W-bit register-file read result, written as one byte.

It uses round-robin arbitration and stalls on the FIFO `full` flag, so no write is ever lost or issued into a full FIFO. It sits in the FIFO write clock domain, between the system controller datapath and the FIFO write-pointer logic.

---
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO-write bundle shared by the arbiter and its neighbours.
// master drives the requests and the full flag; slave is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned W = 8
) ();
  localparam int unsigned CNT_W = 16;

  logic           alu_valid;
  logic [2*W-1:0] alu_data;
  logic           alu_ready;
  logic           rf_valid;
  logic [W-1:0]   rf_data;
  logic           rf_ready;
  logic           full;
  logic           wr_flag;
  logic [W-1:0]   wr_data;
  logic           busy;
  logic [CNT_W-1:0] byte_cnt;

  modport master (
    output alu_valid, alu_data, rf_valid, rf_data, full,
    input  alu_ready, rf_ready, wr_flag, wr_data, busy, byte_cnt
  );

  modport slave (
    input  alu_valid, alu_data, rf_valid, rf_data, full,
    output alu_ready, rf_ready, wr_flag, wr_data, busy, byte_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between a two-byte ALU
// word and a one-byte register-file result; stalls on full, never splits a word.
module fifo_wr_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave arb_if
);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HOLD_W = 2 * W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_RF = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

  logic              alu_grant_c;
  logic              rf_grant_c;
  logic              wr_flag_c;
  logic [W-1:0]      wr_data_c;

  // Grants only in IDLE; on contention the side not granted last wins.
  always_comb begin
    alu_grant_c = 1'b0;
    rf_grant_c  = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      alu_grant_c = arb_if.alu_valid && (!arb_if.rf_valid || last_grant_q);
      rf_grant_c  = arb_if.rf_valid  && (!arb_if.alu_valid || !last_grant_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    last_grant_d = last_grant_q;
    wr_flag_c    = 1'b0;
    wr_data_c    = hold_q[W-1:0];

    unique case (state_q)
      IDLE: begin
        if (alu_grant_c) begin
          hold_d       = arb_if.alu_data;
          last_grant_d = 1'b0;
          state_d      = SEND_LO;
        end else if (rf_grant_c) begin
          hold_d       = {{W{1'b0}}, arb_if.rf_data};
          last_grant_d = 1'b1;
          state_d      = SEND_RF;
        end
      end
      SEND_LO: begin
        if (!arb_if.full) begin
          wr_flag_c = 1'b1;
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        wr_data_c = hold_q[HOLD_W-1:W];
        if (!arb_if.full) begin
          wr_flag_c = 1'b1;
          state_d   = IDLE;
        end
      end
      SEND_RF: begin
        if (!arb_if.full) begin
          wr_flag_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    byte_cnt_d = byte_cnt_q + CNT_W'(wr_flag_c);
  end

  // last_grant resets to RF so the ALU wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      last_grant_q <= 1'b1;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign arb_if.alu_ready = alu_grant_c;
  assign arb_if.rf_ready  = rf_grant_c;
  assign arb_if.wr_flag   = wr_flag_c;
  assign arb_if.wr_data   = wr_data_c;
  assign arb_if.busy      = (state_q != IDLE);
  assign arb_if.byte_cnt  = byte_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a byte-queue reference model.
module tb_fifo_wr_arbiter;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  fifo_wr_arbiter_if #(.W(W)) bus ();

  fifo_wr_arbiter #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model: bytes still owed to the FIFO, in write order.
  logic [7:0]  mq[$];
  logic        m_last_rf = 1'b1;
  logic [15:0] m_cnt     = 16'h0000;
  logic [7:0]  m_hold_lo = 8'h00;
  logic [7:0]  wlog[$];
  bit          keep_req  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (idx < wlog.size()) ? 32'(wlog[idx]) : 32'hDEAD_BEEF;
    chk(tag, obs, 32'(exp));
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic       e_busy, e_ar, e_rr, e_wf;
    logic [7:0] e_wd;
    @(negedge clk);
    e_busy = (mq.size() != 0);
    e_ar   = !rst && !e_busy && bus.alu_valid && (!bus.rf_valid || m_last_rf);
    e_rr   = !rst && !e_busy && bus.rf_valid && (!bus.alu_valid || !m_last_rf);
    e_wf   = e_busy && !bus.full;
    e_wd   = e_busy ? mq[0] : m_hold_lo;
    chk("alu_ready", 32'(bus.alu_ready), 32'(e_ar));
    chk("rf_ready",  32'(bus.rf_ready),  32'(e_rr));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    chk("wr_flag",   32'(bus.wr_flag),   32'(e_wf));
    chk("wr_data",   32'(bus.wr_data),   32'(e_wd));
    chk("byte_cnt",  32'(bus.byte_cnt),  32'(m_cnt));
    if (bus.wr_flag === 1'b1) wlog.push_back(bus.wr_data);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_last_rf = 1'b1;
      m_cnt     = 16'h0000;
      m_hold_lo = 8'h00;
    end else begin
      if (e_wf) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (e_ar) begin
        mq.push_back(bus.alu_data[7:0]);
        mq.push_back(bus.alu_data[15:8]);
        m_last_rf = 1'b0;
        m_hold_lo = bus.alu_data[7:0];
      end else if (e_rr) begin
        mq.push_back(bus.rf_data);
        m_last_rf = 1'b1;
        m_hold_lo = bus.rf_data;
      end
    end
    #1;
    if (!keep_req && e_ar) bus.alu_valid = 1'b0;
    if (!keep_req && e_rr) bus.rf_valid  = 1'b0;
  endtask

  task automatic drain();
    bus.alu_valid = 1'b0;
    bus.rf_valid  = 1'b0;
    bus.full      = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("drain_idle", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    int base;
    int guard;
    rst           = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_data  = '0;
    bus.rf_valid  = 1'b0;
    bus.rf_data   = '0;
    bus.full      = 1'b0;
    @(posedge clk);
    #1;

    // Reset values, with requests present to prove readies are gated.
    bus.alu_valid = 1'b1;
    bus.rf_valid  = 1'b1;
    step();
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_cnt",   32'(bus.byte_cnt), 32'd0);
    chk("rst_wdata", 32'(bus.wr_data),  32'd0);
    bus.alu_valid = 1'b0;
    bus.rf_valid  = 1'b0;
    rst = 1'b0;

    // Single RF byte.
    base = wlog.size();
    bus.rf_valid = 1'b1;
    bus.rf_data  = 8'h5A;
    for (int i = 0; i < 3; i++) step();
    chk_log("rf_byte", base, 8'h5A);
    chk("rf_cnt",  32'(bus.byte_cnt), 32'd1);
    chk("rf_busy", 32'(bus.busy),     32'd0);

    // ALU word, low byte first.
    base = wlog.size();
    bus.alu_valid = 1'b1;
    bus.alu_data  = 16'hBEEF;
    for (int i = 0; i < 4; i++) step();
    chk_log("alu_lo", base,     8'hEF);
    chk_log("alu_hi", base + 1, 8'hBE);
    chk("alu_cnt", 32'(bus.byte_cnt), 32'd3);

    // Continuous contention from reset: ALU first, then alternating.
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = wlog.size();
    keep_req      = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_data  = 16'h1234;
    bus.rf_valid  = 1'b1;
    bus.rf_data   = 8'h77;
    for (int i = 0; i < 12; i++) step();
    chk_log("cont0", base,     8'h34);
    chk_log("cont1", base + 1, 8'h12);
    chk_log("cont2", base + 2, 8'h77);
    chk_log("cont3", base + 3, 8'h34);
    chk_log("cont4", base + 4, 8'h12);
    chk_log("cont5", base + 5, 8'h77);
    keep_req = 1'b0;
    drain();

    // full during SEND_HI: the word stays contiguous despite a waiting RF byte.
    base = wlog.size();
    bus.alu_valid = 1'b1;
    bus.alu_data  = 16'hA1B2;
    step();
    step();
    bus.full     = 1'b1;
    bus.rf_valid = 1'b1;
    bus.rf_data  = 8'hC3;
    for (int i = 0; i < 5; i++) step();
    chk("stall_busy", 32'(bus.busy), 32'd1);
    bus.full = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_log("stall_lo", base,     8'hB2);
    chk_log("stall_hi", base + 1, 8'hA1);
    chk_log("stall_rf", base + 2, 8'hC3);
    chk("stall_len", 32'(wlog.size()), 32'(base + 3));

    // Reset while in SEND_LO.
    bus.alu_valid = 1'b1;
    bus.alu_data  = 16'h5566;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rstmid_busy", 32'(bus.busy),     32'd0);
    chk("rstmid_cnt",  32'(bus.byte_cnt), 32'd0);

    // Random traffic with random back-pressure and occasional reset.
    for (int i = 0; i < 300; i++) begin
      if (!bus.alu_valid) begin
        bus.alu_valid = ($urandom_range(2) == 0);
        bus.alu_data  = 16'($urandom);
      end
      if (!bus.rf_valid) begin
        bus.rf_valid = ($urandom_range(2) == 0);
        bus.rf_data  = 8'($urandom);
      end
      bus.full = ($urandom_range(3) == 0);
      rst      = ($urandom_range(63) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    // Counter wrap using back-to-back ALU words.
    rst = 1'b1;
    step();
    rst = 1'b0;
    keep_req      = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_data  = 16'h0102;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 99000) begin
      step();
      guard++;
    end
    chk("wrap_bound", 32'(guard < 99000), 32'd1);
    chk("wrap_ffff",  32'(bus.byte_cnt),  32'h0000_FFFF);
    step();
    chk("wrap_zero",  32'(bus.byte_cnt),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
